// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: arbitrates the ibex instr and data ports onto one sp_ram port.
// One grant per cycle, combinational grant, 1-cycle response routed back to the owner.
// Addresses outside the RAM window are granted but answered with an error response.
// Build option: define IBEX_ARB_RR_EN for round-robin arbitration; otherwise data has
// fixed priority and a waiting instr request is forced through after MAX_WAIT cycles.
module ibex_mem_arbiter #(
  parameter int unsigned MEM_SIZE  = 65536,
  parameter logic [31:0] MEM_START = 32'h0000_0000,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam logic [31:0] WIN_MASK = ~(32'(MEM_SIZE) - 32'd1);

  logic        instr_win;
  logic        data_win;
  logic        any_gnt;
  logic [31:0] sel_addr;
  logic        sel_in_window;

  logic        resp_valid_reg;
  owner_e      resp_owner_reg;
  logic        resp_err_reg;

`ifdef IBEX_ARB_RR_EN
  owner_e rr_ptr_reg;
  owner_e rr_ptr_next;

  // Round-robin pick: contention goes to the host the pointer names
  always_comb begin
    instr_win = 1'b0;
    data_win  = 1'b0;
    if (instr_req_i && data_req_i) begin
      if (rr_ptr_reg == OWNER_DATA) data_win  = 1'b1;
      else                          instr_win = 1'b1;
    end else begin
      instr_win = instr_req_i;
      data_win  = data_req_i;
    end
  end

  // Pointer moves to the host that did not just win
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (instr_gnt_o)     rr_ptr_next = OWNER_DATA;
    else if (data_gnt_o) rr_ptr_next = OWNER_INSTR;
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_reg <= OWNER_INSTR;
    else         rr_ptr_reg <= rr_ptr_next;
  end
`else
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              instr_starved;

  assign instr_starved = (wait_cnt_reg == WAIT_W'(MAX_WAIT));

  // Fixed data priority, overridden once instr has waited MAX_WAIT cycles
  always_comb begin
    instr_win = 1'b0;
    data_win  = 1'b0;
    if (instr_req_i && (!data_req_i || instr_starved)) instr_win = 1'b1;
    else if (data_req_i)                               data_win  = 1'b1;
  end

  // Count cycles instr is held off; saturate so the override stays armed
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!instr_req_i || instr_gnt_o) wait_cnt_next = '0;
    else if (!instr_starved)         wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  // Starvation counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wait_cnt_reg <= '0;
    else         wait_cnt_reg <= wait_cnt_next;
  end
`endif

  // Grants are held low while reset is asserted so nothing leaks out under reset
  assign instr_gnt_o = instr_win & rst_ni;
  assign data_gnt_o  = data_win & rst_ni;
  assign any_gnt     = instr_gnt_o | data_gnt_o;

  assign sel_addr      = data_win ? data_addr_i : instr_addr_i;
  assign sel_in_window = ((sel_addr & WIN_MASK) == MEM_START);

  // Route only the winner's fields to the RAM; everything is zero when idle
  always_comb begin
    mem_req_o   = any_gnt & sel_in_window;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      mem_addr_o = sel_addr;
      if (data_win) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = 4'hF;
      end
    end
  end

  // Capture owner and error status at grant; the response follows one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_reg <= 1'b0;
      resp_owner_reg <= OWNER_INSTR;
      resp_err_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= any_gnt;
      resp_owner_reg <= data_gnt_o ? OWNER_DATA : OWNER_INSTR;
      resp_err_reg   <= any_gnt & ~sel_in_window;
    end
  end

  // Steer the response to its owner; RAM data without a pending in-window grant is ignored
  always_comb begin
    instr_rvalid_o = resp_valid_reg && (resp_owner_reg == OWNER_INSTR);
    data_rvalid_o  = resp_valid_reg && (resp_owner_reg == OWNER_DATA);
    instr_err_o    = instr_rvalid_o & resp_err_reg;
    data_err_o     = data_rvalid_o & resp_err_reg;
    instr_rdata_o  = 32'h0;
    data_rdata_o   = 32'h0;
    if (resp_valid_reg && !resp_err_reg && mem_rvalid_i) begin
      if (resp_owner_reg == OWNER_DATA) data_rdata_o  = mem_rdata_i;
      else                              instr_rdata_o = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// tb_ibex_mem_arbiter: directed stimulus with a response scoreboard and a behavioural sp_ram.
module tb_ibex_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        is_data;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [31:0] ram [0:16383];

  ibex_mem_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .data_req_i     (data_req),
    .data_we_i      (data_we),
    .data_be_i      (data_be),
    .data_addr_i    (data_addr),
    .data_wdata_i   (data_wdata),
    .data_gnt_o     (data_gnt),
    .data_rvalid_o  (data_rvalid),
    .data_rdata_o   (data_rdata),
    .data_err_o     (data_err),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_be_o       (mem_be),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rvalid_i   (mem_rvalid),
    .mem_rdata_i    (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural sp_ram: 1-cycle read latency, byte-enabled writes, preloaded during reset
  always @(posedge clk) begin
    mem_rvalid <= mem_req;
    mem_rdata  <= 32'h0;
    if (!rst_n) begin
      ram[32] <= 32'h0000_0013;
      ram[64] <= 32'h1234_5678;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[15:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Apply one cycle of inputs just after the clock edge, then settle before checks
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [3:0] dbe, input logic [31:0] da,
                       input logic [31:0] dwd);
    @(posedge clk);
    #1;
    instr_req  = ir;
    instr_addr = ia;
    data_req   = dr;
    data_we    = dwe;
    data_be    = dbe;
    data_addr  = da;
    data_wdata = dwd;
    #3;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic push(input logic is_data, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.err     = err;
    e.rdata   = rdata;
    exp_q.push_back(e);
  endtask

  // Monitor: every response is popped from the scoreboard and compared
  always @(negedge clk) begin
    exp_t e;
    if (instr_rvalid && data_rvalid) begin
      chk("both_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    end else if (instr_rvalid || data_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {30'h0, instr_rvalid, data_rvalid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        $display("rsp %s err=%0b rdata=%h", data_rvalid ? "data " : "instr",
                 data_rvalid ? data_err : instr_err, data_rvalid ? data_rdata : instr_rdata);
        chk("rsp_owner", {31'h0, data_rvalid}, {31'h0, e.is_data});
        if (e.is_data) begin
          chk("rsp_err", {31'h0, data_err}, {31'h0, e.err});
          chk("rsp_rdata", data_rdata, e.rdata);
          chk("nonowner_quiet", {instr_rdata[30:0], instr_err}, 32'h0);
        end else begin
          chk("rsp_err", {31'h0, instr_err}, {31'h0, e.err});
          chk("rsp_rdata", instr_rdata, e.rdata);
          chk("nonowner_quiet", {data_rdata[30:0], data_err}, 32'h0);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    instr_req  = 1'b0;
    instr_addr = 32'h0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #4;
    chk("reset_gnt", {30'h0, instr_gnt, data_gnt}, 32'h0);
    chk("reset_rvalid", {28'h0, instr_rvalid, data_rvalid, instr_err, data_err}, 32'h0);
    chk("reset_mem", {26'h0, mem_req, mem_we, mem_be}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // instr fetch from 0x80
    drive(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t1_gnt", {30'h0, instr_gnt, data_gnt}, 32'h2);
    chk("t1_mem_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h2F);
    chk("t1_mem_addr", mem_addr, 32'h80);
    push(1'b0, 1'b0, 32'h0000_0013);
    idle();
    chk("idle_mem_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h0);
    chk("idle_mem_addr", mem_addr, 32'h0);

    // partial write then read back
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF);
    chk("t2w_gnt", {30'h0, instr_gnt, data_gnt}, 32'h1);
    chk("t2w_mem_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h33);
    chk("t2w_mem_addr", mem_addr, 32'h100);
    chk("t2w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    push(1'b1, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    chk("t2r_mem_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h2F);
    chk("t2r_mem_wdata", mem_wdata, 32'h0);
    push(1'b1, 1'b0, 32'h1234_BEEF);
    idle();

`ifdef IBEX_ARB_RR_EN
    // both requests held: strict alternation starting with instr
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
      if (i % 2 == 0) begin
        chk("t5_gnt", {30'h0, instr_gnt, data_gnt}, 32'h2);
        chk("t5_mem_addr", mem_addr, 32'h80);
        push(1'b0, 1'b0, 32'h0000_0013);
      end else begin
        chk("t5_gnt", {30'h0, instr_gnt, data_gnt}, 32'h1);
        chk("t5_mem_addr", mem_addr, 32'h100);
        push(1'b1, 1'b0, 32'h1234_BEEF);
      end
    end
`else
    // both requests held: data four times, then instr forced through
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
      if (i % 5 == 4) begin
        chk("t3_gnt", {30'h0, instr_gnt, data_gnt}, 32'h2);
        chk("t3_mem_addr", mem_addr, 32'h80);
        chk("t3_mem_be", {28'h0, mem_be}, 32'hF);
        push(1'b0, 1'b0, 32'h0000_0013);
      end else begin
        chk("t3_gnt", {30'h0, instr_gnt, data_gnt}, 32'h1);
        chk("t3_mem_addr", mem_addr, 32'h100);
        push(1'b1, 1'b0, 32'h1234_BEEF);
      end
    end
`endif
    idle();

    // out-of-window data read
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
    chk("t4_gnt", {30'h0, instr_gnt, data_gnt}, 32'h1);
    chk("t4_mem_ctl", {26'h0, mem_req, mem_we, mem_be}, 32'h0);
    chk("t4_mem_addr", mem_addr, 32'h0);
    push(1'b1, 1'b1, 32'h0);
    idle();

    // reset right after a data grant: its response must vanish
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    chk("t6_gnt", {30'h0, instr_gnt, data_gnt}, 32'h1);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    instr_req = 1'b1;
    #3;
    chk("t6_rst_gnt", {30'h0, instr_gnt, data_gnt}, 32'h0);
    chk("t6_rst_rvalid", {28'h0, instr_rvalid, data_rvalid, instr_err, data_err}, 32'h0);
    chk("t6_rst_mem", {26'h0, mem_req, mem_we, mem_be}, 32'h0);
    chk("t6_rst_rdata", data_rdata | instr_rdata | mem_addr | mem_wdata, 32'h0);
    idle();
    idle();
    rst_n = 1'b1;
    repeat (4) idle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
